// File: rtl/switch_debounce_edge.sv
// Debounces one raw asynchronous switch input and emits one-cycle change pulses.
// Optional SWITCH_TOGGLE_EN macro enables the ToggleState latch (else tied to 0).
module switch_debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic SwitchRaw,
  output logic SwitchLevel,
  output logic SwitchFlip,
  output logic RisePulse,
  output logic FallPulse,
  output logic ToggleState
);

  typedef enum logic [0:0] {StStable, StSettling} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             flip_q, rise_q, rise_d, fall_q, fall_d;
  logic             accept;

  // Two-flop synchronizer; only sync2_q is used downstream.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= SwitchRaw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StStable;
      cnt_q   <= '0;
      level_q <= 1'b0;
      flip_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      flip_q  <= accept;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StStable: begin
        if (sync2_q != level_q) begin
          state_d = StSettling;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      StSettling: begin
        // Any bounce back to the held level discards the whole count.
        if (sync2_q == level_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          accept  = 1'b1;
          state_d = StStable;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    level_d = accept ? sync2_q : level_q;
    rise_d  = accept & sync2_q;
    fall_d  = accept & ~sync2_q;
  end

  assign SwitchLevel = level_q;
  assign SwitchFlip  = flip_q;
  assign RisePulse   = rise_q;
  assign FallPulse   = fall_q;

`ifdef SWITCH_TOGGLE_EN
  logic toggle_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      toggle_q <= 1'b0;
    end else if (rise_d) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign ToggleState = toggle_q;
`else
  assign ToggleState = 1'b0;
`endif

endmodule
